rx_bd_sync: RTL

RX_BD_SYNC -- requirements
Module: rx_bd_sync

---
 rtl/rx_bd_sync.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rx_bd_sync.sv
// Symbol-boundary detector: counts a run of alternating BPSK decisions, accepts the first
// repeated symbol as a boundary, then confirms it over a window of further alternations.
module rx_bd_sync #(
    parameter int MAX_WINDOW_WIDTH = 8,
    parameter int PRE_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    input  logic [PRE_WIDTH-1:0]        RX_BD_MIN_PRE,
    input  logic                        BPSK,
    input  logic                        sym_vld,
    input  logic                        PD_flag,
    input  logic                        disassert_BD,
    output logic                        BD_init,
    output logic                        BD_flag,
    output logic                        BD_sgn,
    output logic                        BD_err,
    output logic [1:0]                  BD_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRE     = 2'd1,
        S_CONFIRM = 2'd2,
        S_LOCK    = 2'd3
    } state_t;

    state_t                      r_state;
    logic [PRE_WIDTH-1:0]        r_pre_cnt;
    logic [MAX_WINDOW_WIDTH-1:0] r_cnt;
    logic                        r_bpsk_reg;

    logic                        w_abort;
    logic                        w_diff;
    logic                        w_pre_sat;
    logic                        w_pre_ok;
    logic                        w_win_le1;
    logic [MAX_WINDOW_WIDTH:0]   w_cnt_nxt;
    logic                        w_cnt_done;

    assign w_abort   = disassert_BD | ~PD_flag;
    // diff=0 means the symbol repeated, i.e. a boundary candidate
    assign w_diff    = BPSK ^ r_bpsk_reg;
    assign w_pre_sat = &r_pre_cnt;
    assign w_pre_ok  = (r_pre_cnt >= RX_BD_MIN_PRE);
    assign w_win_le1 = (RX_BD_WINDOW <= MAX_WINDOW_WIDTH'(1));

    // one extra bit so a maximal window never wraps in the compare
    assign w_cnt_nxt  = {1'b0, r_cnt} + (MAX_WINDOW_WIDTH+1)'(1);
    assign w_cnt_done = (w_cnt_nxt >= {1'b0, RX_BD_WINDOW});

    assign BD_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pre_cnt  <= '0;
            r_cnt      <= '0;
            r_bpsk_reg <= 1'b0;
            BD_init    <= 1'b0;
            BD_flag    <= 1'b0;
            BD_sgn     <= 1'b0;
            BD_err     <= 1'b0;
        end else begin
            BD_init <= 1'b0;
            BD_err  <= 1'b0;
            if (sym_vld)
                r_bpsk_reg <= BPSK;

            if (w_abort) begin
                r_state   <= S_IDLE;
                r_pre_cnt <= '0;
                r_cnt     <= '0;
                BD_flag   <= 1'b0;
                BD_sgn    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_PRE;
                        r_pre_cnt <= '0;
                        r_cnt     <= '0;
                    end

                    S_PRE: begin
                        if (sym_vld) begin
                            if (w_diff) begin
                                if (!w_pre_sat)
                                    r_pre_cnt <= r_pre_cnt + PRE_WIDTH'(1);
                            end else if (w_pre_ok) begin
                                BD_init   <= 1'b1;
                                BD_sgn    <= BPSK;
                                r_cnt     <= MAX_WINDOW_WIDTH'(1);
                                r_pre_cnt <= '0;
                                if (w_win_le1) begin
                                    r_state <= S_LOCK;
                                    BD_flag <= 1'b1;
                                end else begin
                                    r_state <= S_CONFIRM;
                                end
                            end else begin
                                r_pre_cnt <= '0;
                            end
                        end
                    end

                    S_CONFIRM: begin
                        if (sym_vld) begin
                            if (w_diff) begin
                                r_cnt <= w_cnt_nxt[MAX_WINDOW_WIDTH-1:0];
                                if (w_cnt_done) begin
                                    r_state <= S_LOCK;
                                    BD_flag <= 1'b1;
                                end
                            end else begin
                                // repeat inside the window: the accepted boundary was false
                                BD_err    <= 1'b1;
                                r_cnt     <= '0;
                                r_pre_cnt <= '0;
                                BD_sgn    <= 1'b0;
                                r_state   <= S_PRE;
                            end
                        end
                    end

                    S_LOCK: begin
                        BD_flag <= 1'b1;
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
